// File: rtl/convolution_controller.sv
// rtl/convolution_controller.sv - streaming KxK convolution sequencer with register slave
// Windows are assembled from the pixel stream, handed to an external MAC, and its sums re-streamed.
module convolution_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int KERNEL_SIZE    = 3,
  parameter int AXI_ADDR_WIDTH = 10
) (
  input  logic                                       axi_clk,
  input  logic                                       axi_reset_n,
  input  logic [DATA_WIDTH-1:0]                      cSum,
  input  logic                                       cReady,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] MULTIPLIER_INPUT,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] MULTIPLICAND_INPUT,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]         MULTIPLY_START,
  input  logic                                       s_axis_valid,
  input  logic [DATA_WIDTH-1:0]                      s_axis_data,
  input  logic                                       s_axis_last,
  output logic                                       s_axis_ready,
  input  logic [DATA_WIDTH/8-1:0]                    s_axis_keep,
  output logic                                       m_axis_valid,
  output logic [DATA_WIDTH-1:0]                      m_axis_data,
  output logic                                       m_axis_last,
  output logic [DATA_WIDTH/8-1:0]                    m_axis_keep,
  input  logic                                       m_axis_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]                  s_axi_awaddr,
  input  logic                                       s_axi_awvalid,
  output logic                                       s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                      s_axi_wdata,
  input  logic                                       s_axi_wvalid,
  output logic                                       s_axi_wready,
  input  logic [AXI_ADDR_WIDTH-1:0]                  s_axi_araddr,
  input  logic                                       s_axi_arvalid,
  output logic                                       s_axi_arready,
  output logic [DATA_WIDTH-1:0]                      s_axi_rdata,
  output logic                                       s_axi_rvalid,
  input  logic                                       s_axi_rready,
  output logic                                       s_axi_bvalid,
  input  logic                                       s_axi_bready
);

  localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_W     = $clog2(KK + 1);
  localparam int FILT_BASE = 24;

  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_CTRL   = AXI_ADDR_WIDTH'(0);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_SOFT   = AXI_ADDR_WIDTH'(4);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_WIDTH  = AXI_ADDR_WIDTH'(16);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_HEIGHT = AXI_ADDR_WIDTH'(20);
  localparam logic [DATA_WIDTH-1:0]     K_DW        = DATA_WIDTH'(KERNEL_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_ctrl_en;
  logic [DATA_WIDTH-1:0]   r_width;
  logic [DATA_WIDTH-1:0]   r_height;
  logic [DATA_WIDTH-1:0]   r_filter [KK];
  logic [DATA_WIDTH-1:0]   r_window [KK];
  logic                    r_bvalid;
  logic                    r_rvalid;
  logic                    r_arready;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_need;
  logic                    r_partial;
  logic [DATA_WIDTH-1:0]   r_col;
  logic [DATA_WIDTH-1:0]   r_row;
  logic [DATA_WIDTH-1:0]   r_sum;
  logic                    w_wr;
  logic                    w_soft;
  logic                    w_beat;
  logic                    w_fill_done;
  logic                    w_out_hs;
  logic                    w_frame_done;
  logic                    w_last_col;
  logic                    w_last_row;
  logic                    w_unused;

  assign w_unused      = ^{s_axis_last, s_axis_keep};
  assign w_wr          = s_axi_awvalid && s_axi_wvalid;
  assign w_soft        = w_wr && (s_axi_awaddr == ADDR_SOFT) && s_axi_wdata[0];
  assign s_axi_awready = w_wr;
  assign s_axi_wready  = w_wr;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_arready = r_arready;

  assign w_need      = r_partial ? CNT_W'(KERNEL_SIZE) : CNT_W'(KK);
  assign w_last_col  = (r_col == r_width - K_DW);
  assign w_last_row  = (r_row == r_height - K_DW);
  assign m_axis_data = r_sum;
  assign m_axis_keep = '1;
  assign m_axis_last = m_axis_valid && w_last_col && w_last_row;

  for (genvar g = 0; g < KK; g++) begin : g_ops
    assign MULTIPLIER_INPUT[g*DATA_WIDTH +: DATA_WIDTH]   = r_window[g];
    assign MULTIPLICAND_INPUT[g*DATA_WIDTH +: DATA_WIDTH] = r_filter[g];
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_ctrl_en <= 1'b0;
      r_width   <= '0;
      r_height  <= '0;
      r_bvalid  <= 1'b0;
      for (int i = 0; i < KK; i++) r_filter[i] <= '0;
    end else begin
      if (w_wr) r_bvalid <= 1'b1;
      else if (s_axi_bready) r_bvalid <= 1'b0;
      if (w_frame_done) r_ctrl_en <= 1'b0;
      // A software write in the same cycle as frame completion takes precedence.
      if (w_wr) begin
        case (s_axi_awaddr)
          ADDR_CTRL:   r_ctrl_en <= s_axi_wdata[0];
          ADDR_SOFT: begin
            if (s_axi_wdata[0]) begin
              r_ctrl_en <= 1'b0;
              r_width   <= '0;
              r_height  <= '0;
            end
          end
          ADDR_WIDTH:  r_width  <= s_axi_wdata;
          ADDR_HEIGHT: r_height <= s_axi_wdata;
          default: ;
        endcase
        for (int i = 0; i < KK; i++) begin
          if (s_axi_awaddr == AXI_ADDR_WIDTH'(FILT_BASE + 4*i)) r_filter[i] <= s_axi_wdata;
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (s_axi_araddr)
      ADDR_CTRL:   w_rd_data = DATA_WIDTH'(r_ctrl_en);
      ADDR_WIDTH:  w_rd_data = r_width;
      ADDR_HEIGHT: w_rd_data = r_height;
      default:     w_rd_data = '0;
    endcase
    for (int i = 0; i < KK; i++) begin
      if (s_axi_araddr == AXI_ADDR_WIDTH'(FILT_BASE + 4*i)) w_rd_data = r_filter[i];
    end
  end

  // arready is registered so it stays low while reset is asserted.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rdata   <= '0;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end else if (s_axi_arvalid && r_arready) begin
      r_rvalid  <= 1'b1;
      r_arready <= 1'b0;
      r_rdata   <= w_rd_data;
    end else begin
      r_arready <= !r_rvalid;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) r_state <= S_IDLE;
    else if (w_soft)  r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    s_axis_ready   = 1'b0;
    MULTIPLY_START = '0;
    m_axis_valid   = 1'b0;
    w_beat         = 1'b0;
    w_fill_done    = 1'b0;
    w_out_hs       = 1'b0;
    w_frame_done   = 1'b0;
    case (r_state)
      S_IDLE: if (r_ctrl_en) w_next = S_FILL;
      S_FILL: begin
        if (r_ctrl_en) begin
          s_axis_ready = 1'b1;
          w_beat       = s_axis_valid;
          w_fill_done  = s_axis_valid && ((r_cnt + CNT_W'(1)) == w_need);
          if (w_fill_done) w_next = S_START;
        end
      end
      S_START: begin
        MULTIPLY_START = '1;
        w_next         = S_WAIT;
      end
      S_WAIT: if (cReady) w_next = S_OUT;
      S_OUT: begin
        m_axis_valid = 1'b1;
        if (m_axis_ready) begin
          w_out_hs     = 1'b1;
          w_frame_done = w_last_col && w_last_row;
          w_next       = w_frame_done ? S_IDLE : S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_cnt     <= '0;
      r_partial <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_sum     <= '0;
      for (int i = 0; i < KK; i++) r_window[i] <= '0;
    end else if (w_soft) begin
      r_cnt     <= '0;
      r_partial <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      if (w_beat) begin
        r_cnt <= w_fill_done ? '0 : r_cnt + CNT_W'(1);
        if (!r_partial) begin
          for (int i = 0; i < KK; i++)
            if (CNT_W'(i) == r_cnt) r_window[i] <= s_axis_data;
        end else begin
          // Each incoming pixel pushes its column up one row; the oldest row drops out.
          for (int i = 0; i < KK - KERNEL_SIZE; i++)
            if (CNT_W'(i % KERNEL_SIZE) == r_cnt) r_window[i] <= r_window[i+KERNEL_SIZE];
          for (int i = KK - KERNEL_SIZE; i < KK; i++)
            if (CNT_W'(i % KERNEL_SIZE) == r_cnt) r_window[i] <= s_axis_data;
        end
      end
      if (r_state == S_WAIT && cReady) r_sum <= cSum;
      if (w_out_hs) begin
        if (w_frame_done) begin
          r_col     <= '0;
          r_row     <= '0;
          r_partial <= 1'b0;
        end else if (w_last_col) begin
          r_col     <= '0;
          r_row     <= r_row + DATA_WIDTH'(1);
          r_partial <= 1'b0;
        end else begin
          r_col     <= r_col + DATA_WIDTH'(1);
          r_partial <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_convolution_controller.sv
// tb/tb_convolution_controller.sv - scoreboard bench for convolution_controller
// The MAC is modelled here; expected windows/sums come from the last K*K pixels of each line.
module tb_convolution_controller;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int KK = 9;
  localparam int AW = 10;

  logic            axi_clk = 1'b0;
  logic            axi_reset_n = 1'b0;
  logic [DW-1:0]   cSum;
  logic            cReady;
  logic [KK*DW-1:0] MULTIPLIER_INPUT;
  logic [KK*DW-1:0] MULTIPLICAND_INPUT;
  logic [KK-1:0]   MULTIPLY_START;
  logic            s_axis_valid = 1'b0;
  logic [DW-1:0]   s_axis_data = '0;
  logic            s_axis_last = 1'b0;
  logic            s_axis_ready;
  logic [0:0]      s_axis_keep = 1'b1;
  logic            m_axis_valid;
  logic [DW-1:0]   m_axis_data;
  logic            m_axis_last;
  logic [0:0]      m_axis_keep;
  logic            m_axis_ready = 1'b1;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata = '0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [AW-1:0]   s_axi_araddr = '0;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [DW-1:0]   s_axi_rdata;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;

  always #5 axi_clk = ~axi_clk;

  convolution_controller #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .AXI_ADDR_WIDTH(AW)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cSum(cSum), .cReady(cReady),
    .MULTIPLIER_INPUT(MULTIPLIER_INPUT), .MULTIPLICAND_INPUT(MULTIPLICAND_INPUT),
    .MULTIPLY_START(MULTIPLY_START),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_ready(s_axis_ready), .s_axis_keep(s_axis_keep),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_keep(m_axis_keep), .m_axis_ready(m_axis_ready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
  );

  int             n_vec = 0;
  int             n_err = 0;
  bit             abort = 1'b0;
  logic [DW-1:0]  tb_filt [KK];
  logic [KK*DW-1:0] exp_win[$];
  logic [DW-1:0]  exp_sum[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KK*DW-1:0] filt_packed();
    logic [KK*DW-1:0] v;
    for (int i = 0; i < KK; i++) v[i*DW +: DW] = tb_filt[i];
    return v;
  endfunction

  task automatic axi_write(input int addr, input int data);
    @(negedge axi_clk);
    s_axi_awaddr = AW'(addr); s_axi_wdata = DW'(data);
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1 check("awready", s_axi_awready, 1);
    @(posedge axi_clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge axi_clk);
    check("bvalid", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    @(posedge axi_clk); #1 s_axi_bready = 1'b0;
    @(negedge axi_clk);
    check("bvalid_clr", s_axi_bvalid, 0);
  endtask

  task automatic axi_read_chk(input string tag, input int addr, input int exp);
    int t = 0;
    @(negedge axi_clk);
    s_axi_araddr = AW'(addr); s_axi_arvalid = 1'b1;
    while (!s_axi_arready && t < 20) begin @(negedge axi_clk); t++; end
    check("arready", s_axi_arready, 1);
    @(posedge axi_clk); #1 s_axi_arvalid = 1'b0;
    @(negedge axi_clk);
    check("rvalid", s_axi_rvalid, 1);
    check(tag, s_axi_rdata, exp);
    s_axi_rready = 1'b1;
    @(posedge axi_clk); #1 s_axi_rready = 1'b0;
  endtask

  task automatic send_px(input logic [DW-1:0] px, input logic last);
    int t = 0;
    @(negedge axi_clk);
    s_axis_data = px; s_axis_last = last; s_axis_valid = 1'b1;
    while (!s_axis_ready && t < 1000) begin @(negedge axi_clk); t++; end
    if (!s_axis_ready) begin
      check("px_accept_timeout", s_axis_ready, 1);
      abort = 1'b1;
      s_axis_valid = 1'b0;
      return;
    end
    @(posedge axi_clk); #1 s_axis_valid = 1'b0;
  endtask

  task automatic drive_frame(input int w, input int h, input bit seq_first);
    logic [DW-1:0]    line[$];
    logic [DW-1:0]    px;
    logic [KK*DW-1:0] win;
    int               sum;
    for (int r = 0; r <= h - K; r++) begin
      line.delete();
      for (int n = 0; n < K*w; n++) begin
        if (abort) return;
        px = (seq_first && r == 0 && n < KK) ? DW'(n) : DW'($urandom_range(0, 7));
        if ((r == 0 && n == 4) || (r == 5 && n == 20)) repeat (3) @(negedge axi_clk);
        send_px(px, (r == h - K) && (n == K*w - 1));
        line.push_back(px);
        if (n >= KK - 1 && (n - (KK - 1)) % K == 0) begin
          sum = 0;
          for (int i = 0; i < KK; i++) begin
            win[i*DW +: DW] = line[line.size() - KK + i];
            sum += int'(tb_filt[i]) * int'(line[line.size() - KK + i]);
          end
          exp_win.push_back(win);
          exp_sum.push_back(DW'(sum));
        end
      end
    end
  endtask

  task automatic mon_frame(input int n);
    int            t;
    logic [DW-1:0] d0;
    logic [DW-1:0] e;
    for (int k = 0; k < n; k++) begin
      if (abort) break;
      @(negedge axi_clk);
      t = 0;
      while (!m_axis_valid && t < 300) begin @(negedge axi_clk); t++; end
      if (!m_axis_valid) begin
        check("out_timeout", m_axis_valid, 1);
        abort = 1'b1;
        break;
      end
      if (k == 0 || k == 30) begin
        d0 = m_axis_data;
        m_axis_ready = 1'b0;
        repeat (5) begin
          @(negedge axi_clk);
          check("stall_valid", m_axis_valid, 1);
          check("stall_data", m_axis_data, d0);
          check("stall_sready", s_axis_ready, 0);
        end
        m_axis_ready = 1'b1;
      end
      if (exp_sum.size() == 0) check("sum_q_empty", m_axis_valid, 0);
      else begin
        e = exp_sum.pop_front();
        check("out_data", m_axis_data, e);
      end
      check("out_last", m_axis_last, (k == n - 1));
      @(posedge axi_clk);
      @(negedge axi_clk);
      check("valid_gap", m_axis_valid, 0);
      check("last_drop", m_axis_last, 0);
    end
  endtask

  // External MAC: answers each start pulse after a random latency.
  initial begin
    int               s;
    logic [KK*DW-1:0] w;
    cReady = 1'b0;
    cSum   = '0;
    forever begin
      @(negedge axi_clk);
      if (MULTIPLY_START != '0) begin
        check("mstart", MULTIPLY_START, 9'h1FF);
        if (exp_win.size() == 0) check("win_q_empty", MULTIPLY_START, 0);
        else begin
          w = exp_win.pop_front();
          check("window", MULTIPLIER_INPUT, w);
        end
        check("filters", MULTIPLICAND_INPUT, filt_packed());
        s = 0;
        for (int i = 0; i < KK; i++)
          s += int'(MULTIPLIER_INPUT[i*DW +: DW]) * int'(MULTIPLICAND_INPUT[i*DW +: DW]);
        @(negedge axi_clk);
        check("mstart_1cyc", MULTIPLY_START, 0);
        repeat ($urandom_range(0, 2)) @(negedge axi_clk);
        cSum = DW'(s); cReady = 1'b1;
        @(negedge axi_clk);
        cReady = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge axi_clk);
    check("rst_sready", s_axis_ready, 0);
    check("rst_mvalid", m_axis_valid, 0);
    check("rst_mlast", m_axis_last, 0);
    check("rst_mdata", m_axis_data, 0);
    check("rst_mkeep", m_axis_keep, 1);
    check("rst_mstart", MULTIPLY_START, 0);
    check("rst_window", MULTIPLIER_INPUT, 0);
    check("rst_filters", MULTIPLICAND_INPUT, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_arready", s_axi_arready, 0);
    axi_reset_n = 1'b1;
    repeat (2) @(negedge axi_clk);

    axi_write(0, 1);
    axi_write(16, 25);
    axi_read_chk("rd_width", 16, 25);
    axi_read_chk("rd_ctrl", 0, 1);
    @(negedge axi_clk);
    check("fill_sready", s_axis_ready, 1);
    axi_write(4, 1);
    axi_read_chk("rd_width_srst", 16, 0);
    axi_read_chk("rd_ctrl_srst", 0, 0);
    axi_read_chk("rd_soft_selfclr", 4, 0);
    @(negedge axi_clk);
    check("srst_sready", s_axis_ready, 0);

    for (int i = 0; i < KK; i++) begin
      tb_filt[i] = DW'(i);
      axi_write(24 + 4*i, i);
    end
    axi_write(16, 25);
    axi_write(20, 25);
    axi_read_chk("rd_filter5", 44, 5);
    axi_read_chk("rd_unmapped", 8, 0);
    axi_write(0, 1);
    fork
      drive_frame(25, 25, 1'b1);
      mon_frame(529);
    join
    axi_read_chk("rd_ctrl_done", 0, 0);
    @(negedge axi_clk);
    check("done_sready", s_axis_ready, 0);

    for (int i = 0; i < KK; i++) begin
      tb_filt[i] = DW'(200 + i);
      axi_write(24 + 4*i, 200 + i);
    end
    axi_write(16, 4);
    axi_write(20, 4);
    axi_write(0, 1);
    fork
      drive_frame(4, 4, 1'b0);
      mon_frame(4);
    join
    axi_read_chk("rd_ctrl_done2", 0, 0);
    check("sum_q_left", exp_sum.size(), 0);
    check("win_q_left", exp_win.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/convolution_controller.md
Name: convolution_controller

Overview:
- Streaming 2-D convolution sequencer for a KxK kernel.
- Receives pixels on an AXI4-Stream slave and assembles KxK windows.
- For each window, drives flat operand buses to an external matrix multiply-accumulate unit and waits for its sum.
- Emits each sum on an AXI4-Stream master. Filter coefficients, image size and control are written over an AXI4-Lite-style slave.

Parameters:
- DATA_WIDTH, 8, pixel/coefficient/result width.
- KERNEL_SIZE, 3, kernel dimension K (window holds K*K entries).
- AXI_ADDR_WIDTH, 10, register address width.

Ports:
- axi_clk  in  1  clock
- axi_reset_n  in  1  async active-low reset
- cSum  in  DATA_WIDTH  accumulated result from MAC unit
- cReady  in  1  cSum valid
- MULTIPLIER_INPUT  out  K*K*DATA_WIDTH  window[i] at bits [i*DW +: DW]
- MULTIPLICAND_INPUT  out  K*K*DATA_WIDTH  filter[i] at bits [i*DW +: DW]
- MULTIPLY_START  out  K*K  per-multiplier start
- s_axis_valid/ s_axis_data(DW)/ s_axis_last  in; s_axis_ready  out; s_axis_keep  in  DW/8
- m_axis_valid/ m_axis_data(DW)/ m_axis_last/ m_axis_keep(DW/8)  out; m_axis_ready  in
- s_axi_awaddr(AXI_ADDR_WIDTH)/ s_axi_awvalid  in; s_axi_awready  out
- s_axi_wdata(DW)/ s_axi_wvalid  in; s_axi_wready  out
- s_axi_araddr(AXI_ADDR_WIDTH)/ s_axi_arvalid  in; s_axi_arready  out
- s_axi_rdata(DW)/ s_axi_rvalid  out; s_axi_rready  in
- s_axi_bvalid  out; s_axi_bready  in

Behaviour:
- Reset: single clock axi_clk; reset is asynchronous, active-low on axi_reset_n. All outputs are 0, except m_axis_keep, which is all-ones. All registers, window and counters are 0; FSM is IDLE.
- Register map (byte addresses):
  - 0 CTRL: bit0 enable.
  - 4 SOFT_RESET: writing 1 clears CTRL, WIDTH, HEIGHT, counters and FSM to IDLE, same cycle effect. Filters are kept. The register self-clears.
  - 16 WIDTH.
  - 20 HEIGHT.
  - 24+4*i FILTER[i], i=0..K*K-1.
  - Other addresses: writes ignored, reads return 0.
- Write channel:
  - Accepted in any cycle with awvalid&&wvalid; awready/wready are asserted combinationally in that cycle.
  - bvalid asserts the next cycle and holds until bready.
- Read channel:
  - arready=1 while no read is pending.
  - On arvalid, rdata is registered next cycle with rvalid, held until rready.
- Window fill, per output line:
  - First window: K*K pixels accepted in order into window[0..K*K-1].
  - Each later window: K pixels. For incoming index j=K*(K-1)..K*K-1: window[j-2K]<=window[j-K], window[j-K]<=window[j], window[j]<=pixel.
- Windows and outputs:
  - WIDTH-K+1 windows per line, HEIGHT-K+1 lines.
  - Total outputs per frame: (WIDTH-K+1)*(HEIGHT-K+1).
- FSM:
  - IDLE -> FILL when enable=1.
  - FILL: s_axis_ready=1; count beats where valid&&ready; s_axis_keep is ignored. When the required count is reached -> START.
  - START: MULTIPLY_START = all ones for exactly 1 cycle; operands are stable from this cycle through WAIT -> WAIT.
  - WAIT: on cReady, capture cSum -> OUT.
  - OUT: m_axis_valid=1, m_axis_data=captured sum (modulo 2^DW), held until m_axis_ready. After the handshake, m_axis_valid drops for at least 1 cycle. Then:
    - frame done -> IDLE and clear enable;
    - otherwise -> FILL, needing K*K pixels if the line is done, else K.
- s_axis_ready=0 outside FILL.
- m_axis_last=1 together with m_axis_valid for the final frame output only; it deasserts with valid.
- s_axis_last is informational only: early last does not truncate the frame.
- enable=0 mid-frame pauses at the next FILL entry; the window is preserved.
- Writes during operation update registers immediately. Software must not change WIDTH/HEIGHT mid-frame.
- Overflow: results wrap modulo 2^DW; no saturation.

Test Plan:
- Reset, write CTRL=1, WIDTH=25, read back addr 16 -> rdata=25 with rvalid; bvalid follows each write.
- Write SOFT_RESET=1 after WIDTH=25 -> WIDTH reads 0, CTRL reads 0, s_axis_ready=0.
- FILTER[i]=i, enable, WIDTH=HEIGHT=25, stream pixels 0..8 -> MULTIPLY_START=9'h1FF one cycle; MULTIPLIER_INPUT byte i=i.
  - MAC returns cSum=204 (sum i*i) -> m_axis_data=204.
- Full 25x25 frame with random pixels 0..7:
  - 529 outputs, each equal to sum filter[i]*window[i] mod 256;
  - 23 per line, new line requires 9 pixels;
  - m_axis_last only on the 529th output.
- Hold m_axis_ready=0 for 5 cycles during OUT -> m_axis_valid and data stay stable, s_axis_ready stays 0, no pixel accepted.
- Gap s_axis_valid mid-fill for 3 cycles -> no beat counted; window content correct after resume.
